// File: rtl/nn_cost_window_integrator_if.sv
// Handshake/data bundle between the window integrator and its producer/consumer.
// The master side drives the error stream and control; the slave side is the integrator.
interface nn_cost_window_integrator_if #(
   parameter int unsigned CntW = 10
) ();
   logic                   start;
   logic                   abort;
   logic                   err_bit;
   logic                   err_sign;
   logic                   ack;
   logic                   busy;
   logic signed [CntW-1:0] result;
   logic                   result_valid;
   logic                   err_zero;
   logic                   sat;

   modport master (
      output start, abort, err_bit, err_sign, ack,
      input  busy, result, result_valid, err_zero, sat
   );

   modport slave (
      input  start, abort, err_bit, err_sign, ack,
      output busy, result, result_valid, err_zero, sat
   );
endinterface

// File: rtl/nn_cost_window_integrator.sv
// Integrates a signed stochastic error stream over a fixed window into a saturating count and
// hands the result to the consumer through a VALID/ACK handshake.
module nn_cost_window_integrator #(
   parameter int unsigned WindowLen = 256,
   parameter int unsigned WinW      = 9,
   parameter int unsigned CntW      = 10,
   parameter int unsigned Deadband  = 2
) (
   input logic                        clk_i,
   input logic                        rst_ni,
   nn_cost_window_integrator_if.slave bus_io
);

   // Symmetric clamp: the most-negative code is never produced.
   localparam logic signed [CntW-1:0] AccMax = {1'b0, {(CntW-1){1'b1}}};
   localparam logic signed [CntW-1:0] AccMin = -AccMax;
   localparam logic signed [CntW-1:0] AccOne = CntW'(1);
   localparam logic signed [CntW-1:0] DbPos  = CntW'(Deadband);
   localparam logic signed [CntW-1:0] DbNeg  = -DbPos;
   localparam logic [WinW-1:0]        WinLast = WinW'(WindowLen - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q, state_d;
   logic signed [CntW-1:0] acc_q, acc_d, acc_upd;
   logic signed [CntW-1:0] result_q, result_d;
   logic [WinW-1:0]        win_q, win_d;
   logic                   valid_q, valid_d;
   logic                   zero_q, zero_d;
   logic                   sat_q, sat_d;
   logic                   clamp;

   always_comb begin
      acc_upd = acc_q;
      clamp   = 1'b0;
      if (bus_io.err_bit) begin
         if (!bus_io.err_sign) begin
            if (acc_q == AccMax) clamp = 1'b1;
            else                 acc_upd = acc_q + AccOne;
         end else begin
            if (acc_q == AccMin) clamp = 1'b1;
            else                 acc_upd = acc_q - AccOne;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      win_d    = win_q;
      result_d = result_q;
      valid_d  = valid_q;
      zero_d   = zero_q;
      sat_d    = sat_q;
      if (bus_io.abort) begin
         state_d = StIdle;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.start) begin
                  state_d = StRun;
                  acc_d   = '0;
                  win_d   = '0;
                  sat_d   = 1'b0;
               end
            end
            StRun: begin
               acc_d = acc_upd;
               win_d = win_q + 1'b1;
               sat_d = sat_q | clamp;
               if (win_q == WinLast) begin
                  result_d = acc_upd;
                  valid_d  = 1'b1;
                  zero_d   = (acc_upd <= DbPos) && (acc_upd >= DbNeg);
                  state_d  = StDone;
               end
            end
            StDone: begin
               if (bus_io.ack) begin
                  valid_d = 1'b0;
                  // ACK with START chains straight into the next window.
                  if (bus_io.start) begin
                     state_d = StRun;
                     acc_d   = '0;
                     win_d   = '0;
                     sat_d   = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         win_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         zero_q   <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         win_q    <= win_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         zero_q   <= zero_d;
         sat_q    <= sat_d;
      end
   end

   assign bus_io.busy         = (state_q == StRun);
   assign bus_io.result       = result_q;
   assign bus_io.result_valid = valid_q;
   assign bus_io.err_zero     = zero_q & valid_q;
   assign bus_io.sat          = sat_q;

endmodule
